// File: rtl/polycore_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// polycore_rr_arbiter_if
// Bundles the requester-side and core-side signals of the polynomial-core
// arbiter into one interface.
//   req_rtr / req_inp        requester job request and operands (packed, req i
//                            at [POLY_W*i +: POLY_W])
//   req_rts / req_grant      per-requester job-done and one-hot core ownership
//   out_data                 result of the last completed job
//   core_rtr / core_inp      start/hold and operand towards the core
//   core_out / core_rts      result and done from the core
//   busy / timeout_err       arbiter status
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters plus core) driving the arbiter
// ---------------------------------------------------------------------------
interface polycore_rr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int POLY_W = 8192
);
  logic [NREQ-1:0]        req_rtr;
  logic [NREQ*POLY_W-1:0] req_inp;
  logic [NREQ-1:0]        req_rts;
  logic [NREQ-1:0]        req_grant;
  logic [POLY_W-1:0]      out_data;
  logic                   core_rtr;
  logic [POLY_W-1:0]      core_inp;
  logic [POLY_W-1:0]      core_out;
  logic                   core_rts;
  logic                   busy;
  logic                   timeout_err;

  modport slave (
    input  req_rtr, req_inp, core_out, core_rts,
    output req_rts, req_grant, out_data, core_rtr, core_inp, busy, timeout_err
  );

  modport master (
    output req_rtr, req_inp, core_out, core_rts,
    input  req_rts, req_grant, out_data, core_rtr, core_inp, busy, timeout_err
  );
endinterface

// File: rtl/polycore_rr_arbiter.sv
// ---------------------------------------------------------------------------
// polycore_rr_arbiter
// Shares one polynomial transform core between NREQ requesters. A single job
// (one polynomial in, one polynomial out) runs at a time; the owner is chosen
// round-robin starting after the last served requester. Operand and result
// are registered. A watchdog aborts a job whose core never reports done; the
// abort is flagged sticky on timeout_err and the arbiter keeps serving.
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   bus     polycore_rr_arbiter_if.slave (requester + core handshakes, status)
// Parameters:
//   NREQ (2..8), POLY_W, TIMEOUT (max RUN cycles), CNT_W (2**CNT_W > TIMEOUT)
// ---------------------------------------------------------------------------
module polycore_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int POLY_W  = 8192,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 13
) (
  input  logic                        clock,
  input  logic                        reset,
  polycore_rr_arbiter_if.slave        bus
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    RELEASE,
    DONE
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  g;
  logic [CNT_W-1:0]  wdog;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   rts_q;
  logic [POLY_W-1:0] out_q;
  logic [POLY_W-1:0] core_inp_q;
  logic              tmo_q;

  // Round-robin pick: requests strictly above the last owner win first;
  // if none, wrap around and take the lowest request overall.
  logic [NREQ-1:0]   above_last;
  logic [NREQ-1:0]   masked;
  logic [NREQ-1:0]   pick_vec;
  logic [IDX_W-1:0]  pick_idx;

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    above_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      above_last[i] = (i > int'(last));
    end
    masked   = bus.req_rtr & above_last;
    pick_vec = (masked != '0) ? masked : bus.req_rtr;
    pick_idx = '0;
    // Scanning downwards leaves the lowest set bit in pick_idx.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick_vec[i]) pick_idx = IDX_W'(i);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last       <= IDX_W'(NREQ - 1);
      g          <= '0;
      wdog       <= '0;
      grant_q    <= '0;
      rts_q      <= '0;
      tmo_q      <= 1'b0;
      // NOTE: the wide operand/result registers are cleared as well, so a
      // reset never exposes a stale polynomial on out_data or core_inp.
      out_q      <= '0;
      core_inp_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.req_rtr) begin
            g       <= pick_idx;
            grant_q <= NREQ'(1) << pick_idx;
            state   <= LOAD;
          end
        end
        LOAD: begin
          // Operand is frozen here; later req_inp changes are ignored.
          core_inp_q <= bus.req_inp[int'(g)*POLY_W +: POLY_W];
          wdog       <= '0;
          state      <= RUN;
        end
        RUN: begin
          if (bus.core_rts) begin
            out_q <= bus.core_out;
            state <= RELEASE;
          end else if (wdog == CNT_W'(TIMEOUT - 1)) begin
            // Abort: result register keeps the previous job's value.
            tmo_q <= 1'b1;
            rts_q <= grant_q;
            state <= DONE;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        RELEASE: begin
          // Complete the core's 4-phase handshake before reporting.
          if (!bus.core_rts) begin
            rts_q <= grant_q;
            state <= DONE;
          end
        end
        DONE: begin
          // Hold job-done until the owner withdraws its request.
          if (!bus.req_rtr[g]) begin
            last    <= g;
            grant_q <= '0;
            rts_q   <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_rtr    = (state == RUN) & ~bus.core_rts;
  assign bus.busy        = (state != IDLE);
  assign bus.req_grant   = grant_q;
  assign bus.req_rts     = rts_q;
  assign bus.out_data    = out_q;
  assign bus.core_inp    = core_inp_q;
  assign bus.timeout_err = tmo_q;

endmodule

// File: tb/tb_polycore_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_polycore_rr_arbiter
// Self-checking bench for polycore_rr_arbiter. An environment process plays
// the requesters and the core; a job-level reference model predicts every
// output each cycle; directed scenarios pin the model with literal values,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_polycore_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int POLY_W  = 64;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  typedef logic [POLY_W-1:0] word_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  polycore_rr_arbiter_if #(.NREQ(NREQ), .POLY_W(POLY_W)) bus ();

  polycore_rr_arbiter #(
    .NREQ(NREQ), .POLY_W(POLY_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t rand_word();
    return {$urandom, $urandom};
  endfunction

  function automatic word_t onehot(input int i);
    word_t w;
    w = '0;
    if (i >= 0) w[i] = 1'b1;
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Environment knobs (written only by the main sequence)
  // mode 0: requesters follow hand_rtr/hand_inp
  // mode 1: every requester re-requests as soon as it is free, drops on rts
  // mode 2: random request / drop-on-rts / occasional withdrawal mid-job
  // -------------------------------------------------------------------------
  int                     mode      = 0;
  logic [NREQ-1:0]        hand_rtr  = '0;
  logic [NREQ*POLY_W-1:0] hand_inp  = '0;
  int                     core_lat  = 10;   // core_rtr cycles before core_rts; <0 never
  int                     core_hold = 0;    // extra cycles core_rts stays high
  bit                     core_rand = 1'b0;
  word_t                  core_val  = '0;

  // Environment-owned state
  logic [NREQ-1:0]        a_rtr = '0;
  logic [NREQ*POLY_W-1:0] a_inp = '0;
  int c_cnt = 0, c_hold_left = 0, r_lat = 5, r_hold = 0;

  always @(negedge clock) begin : env
    int lat;
    lat = core_rand ? r_lat : core_lat;
    if (!reset) begin
      bus.core_rts = 1'b0;
      c_cnt        = 0;
      c_hold_left  = 0;
    end else if (bus.core_rts) begin
      if (c_hold_left > 0) c_hold_left--;
      else begin
        bus.core_rts = 1'b0;
        bus.core_out = rand_word();
      end
    end else if (bus.core_rtr) begin
      c_cnt++;
      if (lat >= 0 && c_cnt >= lat) begin
        bus.core_rts = 1'b1;
        bus.core_out = core_rand ? rand_word() : core_val;
        c_hold_left  = core_rand ? r_hold : core_hold;
        c_cnt        = 0;
        r_lat        = $urandom_range(1, 20);
        r_hold       = $urandom_range(0, 3);
      end
    end else begin
      c_cnt = 0;
    end

    if (mode == 0) begin
      a_rtr = hand_rtr;
      a_inp = hand_inp;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (a_rtr[i] && bus.req_rts[i]) begin
          a_rtr[i] = 1'b0;
        end else if (!a_rtr[i] && !bus.req_grant[i] &&
                     (mode == 1 || $urandom_range(0, 3) == 0)) begin
          a_inp[i*POLY_W +: POLY_W] = rand_word();
          a_rtr[i] = 1'b1;
        end else if (mode == 2 && a_rtr[i] && bus.req_grant[i] && !bus.req_rts[i] &&
                     $urandom_range(0, 63) == 0) begin
          a_rtr[i] = 1'b0;
        end
      end
    end
    bus.req_rtr = a_rtr;
    bus.req_inp = a_inp;
  end

  // -------------------------------------------------------------------------
  // Reference model: tracks the current job (owner, operand, result) and
  // derives expected outputs from the job's progress.
  // -------------------------------------------------------------------------
  int    j_owner = -1;   // -1: no job
  bit    j_loaded, j_result, j_report, j_tmo_job;
  int    j_run;
  int    m_last = NREQ - 1;
  word_t e_inp = '0, e_out = '0;
  bit    e_tmo = 1'b0;
  int    waits[NREQ];
  int    grant_log[$];
  logic [NREQ-1:0] prev_grant = '0;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clock) begin : model
    logic [NREQ-1:0]        s_rtr;
    logic [NREQ*POLY_W-1:0] s_inp;
    logic                   s_crts;
    word_t                  s_cout;
    int                     worst;
    bit                     exp_core_rtr;
    s_rtr  = bus.req_rtr;
    s_inp  = bus.req_inp;
    s_crts = bus.core_rts;
    s_cout = bus.core_out;
    if (!reset) begin
      j_owner = -1; j_loaded = 0; j_result = 0; j_report = 0; j_tmo_job = 0; j_run = 0;
      m_last  = NREQ - 1;
      e_inp   = '0; e_out = '0; e_tmo = 1'b0;
      for (int i = 0; i < NREQ; i++) waits[i] = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) if (!s_rtr[i]) waits[i] = 0;
      if (j_owner < 0) begin
        if (s_rtr != '0) begin
          j_owner = rr_pick(s_rtr, m_last);
          j_loaded = 0; j_result = 0; j_report = 0; j_tmo_job = 0; j_run = 0;
          worst = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (i == j_owner) waits[i] = 0;
            else if (s_rtr[i]) begin
              waits[i]++;
              if (waits[i] > worst) worst = waits[i];
            end
          end
          check("starvation_bound", word_t'(worst <= NREQ - 1), word_t'(1));
        end
      end else if (j_report) begin
        if (!s_rtr[j_owner]) begin
          m_last   = j_owner;
          j_owner  = -1;
          j_report = 0;
        end
      end else if (!j_loaded) begin
        e_inp    = s_inp[j_owner*POLY_W +: POLY_W];
        j_loaded = 1;
      end else if (!j_result && !j_tmo_job) begin
        if (s_crts) begin
          e_out    = s_cout;
          j_result = 1;
        end else begin
          j_run++;
          if (j_run == TIMEOUT) begin
            e_tmo = 1'b1; j_tmo_job = 1; j_report = 1;
          end
        end
      end else if (!s_crts) begin
        j_report = 1;
      end
    end

    #1;
    if (bus.req_grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < NREQ; i++) if (bus.req_grant[i]) grant_log.push_back(i);
    end
    prev_grant = bus.req_grant;

    exp_core_rtr = (j_owner >= 0) && j_loaded && !j_result && !j_tmo_job && !bus.core_rts;
    check("busy",        word_t'(bus.busy),        word_t'(j_owner >= 0));
    check("req_grant",   word_t'(bus.req_grant),   onehot(j_owner));
    check("req_rts",     word_t'(bus.req_rts),     j_report ? onehot(j_owner) : '0);
    check("core_rtr",    word_t'(bus.core_rtr),    word_t'(exp_core_rtr));
    check("core_inp",    bus.core_inp,             e_inp);
    check("out_data",    bus.out_data,             e_out);
    check("timeout_err", word_t'(bus.timeout_err), word_t'(e_tmo));
  end

  // -------------------------------------------------------------------------
  // Sequence helpers (all return at posedge+2, after the model compare)
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    mode      = 0;
    hand_rtr  = '0;
    core_rand = 1'b0;
    core_hold = 0;
    reset     = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_rts(input string name, input int budget);
    for (int n = 0; n < budget && bus.req_rts == '0; n++) tick();
    check(name, word_t'(bus.req_rts != '0), word_t'(1));
  endtask

  task automatic wait_core_rtr(input string name, input int budget);
    for (int n = 0; n < budget && !bus.core_rtr; n++) tick();
    check(name, word_t'(bus.core_rtr), word_t'(1));
  endtask

  initial begin : main
    int    g0, cnt, first_rts, last_crts, crts_cnt;
    int    exp_order[5];
    word_t x1, x2;
    exp_order = '{0, 1, 2, 3, 0};

    // Reset state
    do_reset();
    check("rst_grant",   word_t'(bus.req_grant),   '0);
    check("rst_rts",     word_t'(bus.req_rts),     '0);
    check("rst_busy",    word_t'(bus.busy),        '0);
    check("rst_out",     bus.out_data,             '0);
    check("rst_core_inp", bus.core_inp,            '0);

    // 1: single request, core answers after 10 cycles
    core_lat = 10;
    core_val = 64'hC0FF_EE00_1234_5678;
    hand_inp = {rand_word(), rand_word(), rand_word(), 64'h1111_2222_3333_4444};
    hand_rtr = 4'b0001;
    tick();
    check("t1_grant",    word_t'(bus.req_grant), word_t'(4'b0001));
    tick();
    check("t1_core_rtr", word_t'(bus.core_rtr),  word_t'(1));
    check("t1_core_inp", bus.core_inp,           64'h1111_2222_3333_4444);
    wait_rts("t1_rts_seen", 40);
    check("t1_rts",      word_t'(bus.req_rts),   word_t'(4'b0001));
    check("t1_out",      bus.out_data,           64'hC0FF_EE00_1234_5678);
    hand_rtr = '0;
    tick();
    tick();
    check("t1_idle",     word_t'(bus.busy),      '0);

    // 2: all four request together and keep re-requesting
    do_reset();
    core_lat = 3;
    g0 = grant_log.size();
    mode = 1;
    for (int n = 0; n < 300 && grant_log.size() < g0 + 5; n++) tick();
    check("t2_jobs", word_t'(grant_log.size() >= g0 + 5), word_t'(1));
    if (grant_log.size() >= g0 + 5) begin
      for (int k = 0; k < 5; k++)
        check("t2_order", word_t'(grant_log[g0 + k]), word_t'(exp_order[k]));
    end

    // 3: requester 2 withdraws during RUN
    do_reset();
    core_lat = 5;
    hand_rtr = 4'b0100;
    wait_core_rtr("t3_run", 20);
    hand_rtr = '0;
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (bus.req_rts[2]) cnt++;
    end
    check("t3_rts_len", word_t'(cnt), word_t'(1));
    check("t3_idle",    word_t'(bus.busy), '0);

    // 4: watchdog abort between two normal jobs
    do_reset();
    x1 = 64'hAAAA_0000_5555_0001;
    x2 = 64'hBBBB_0000_6666_0002;
    core_lat = 4; core_val = x1;
    hand_rtr = 4'b0010;
    wait_rts("t4_job1", 40);
    check("t4_out1", bus.out_data, x1);
    hand_rtr = '0;
    repeat (2) tick();
    core_lat = -1;
    hand_rtr = 4'b0010;
    cnt = 0;
    for (int n = 0; n < 60 && bus.req_rts == '0; n++) begin
      tick();
      if (bus.core_rtr) cnt++;
    end
    check("t4_run_cycles", word_t'(cnt), word_t'(TIMEOUT));
    check("t4_tmo",        word_t'(bus.timeout_err), word_t'(1));
    check("t4_out_kept",   bus.out_data, x1);
    hand_rtr = '0;
    repeat (2) tick();
    core_lat = 4; core_val = x2;
    hand_rtr = 4'b0001;
    wait_rts("t4_job3", 40);
    check("t4_out3",       bus.out_data, x2);
    check("t4_tmo_sticky", word_t'(bus.timeout_err), word_t'(1));
    hand_rtr = '0;
    repeat (2) tick();

    // 5: core holds core_rts for 3 extra cycles
    do_reset();
    core_lat = 3; core_hold = 3;
    hand_rtr = 4'b1000;
    crts_cnt = 0; last_crts = -1; first_rts = -1;
    for (int n = 0; n < 60 && first_rts < 0; n++) begin
      tick();
      if (bus.core_rts) begin crts_cnt++; last_crts = n; end
      if (bus.req_rts != '0) first_rts = n;
    end
    check("t5_core_rts_cycles", word_t'(crts_cnt), word_t'(4));
    // req_rts shows up in the first sample after the core is seen released
    check("t5_rts_after_release", word_t'(first_rts - last_crts), word_t'(1));
    hand_rtr = '0;
    core_hold = 0;
    repeat (2) tick();

    // 6: asynchronous reset in the middle of RUN
    do_reset();
    core_lat = 3; core_val = 64'h0123_4567_89AB_CDEF;
    hand_inp = {rand_word(), rand_word(), rand_word(), rand_word()};
    hand_rtr = 4'b0001;
    wait_rts("t6_job0", 40);
    hand_rtr = '0;
    repeat (2) tick();
    core_lat = 8;
    hand_rtr = 4'b0100;
    wait_core_rtr("t6_run", 20);
    tick();
    #1 reset = 1'b0;
    #1;
    check("t6_grant",    word_t'(bus.req_grant), '0);
    check("t6_rts",      word_t'(bus.req_rts),   '0);
    check("t6_core_rtr", word_t'(bus.core_rtr),  '0);
    check("t6_busy",     word_t'(bus.busy),      '0);
    check("t6_out",      bus.out_data,           '0);
    check("t6_core_inp", bus.core_inp,           '0);
    hand_rtr = 4'b0011;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick();
    check("t6_rr_restart", word_t'(bus.req_grant), word_t'(4'b0001));
    hand_rtr = '0;
    for (int n = 0; n < 40 && bus.busy; n++) tick();

    // Randomized traffic with random core latency, hold and timeouts
    do_reset();
    core_rand = 1'b1;
    mode = 2;
    repeat (3000) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
